// File: rtl/fpu_div_pkg.sv
// Shared types and constants for the FP divide/sqrt scheduler.
package fpu_div_pkg;

  localparam int unsigned OP_W       = 13;
  localparam int unsigned DATA_W     = 68;
  localparam int unsigned FLAG_W     = 11;
  localparam int unsigned OP_DBL_BIT = 7;
  localparam int unsigned NREQ_DEF   = 3;
  localparam int unsigned TAG_W_DEF  = 9;
  localparam int unsigned LAT_S_DEF  = 10;
  localparam int unsigned LAT_D_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    HOLD  = 2'd3
  } state_e;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } div_cmd_t;

  typedef struct packed {
    logic [DATA_W-1:0] res;
    logic [FLAG_W-1:0] flags;
  } div_rsp_t;

endpackage

// File: rtl/fpu_div_sched_if.sv
// Request, divider and writeback signals of the shared divide scheduler.
interface fpu_div_sched_if #(
  parameter int unsigned NREQ  = 3,
  parameter int unsigned TAG_W = 9
);
  import fpu_div_pkg::*;

  logic [NREQ-1:0]        rq_valid;
  logic [NREQ-1:0]        rq_ready;
  logic [NREQ*OP_W-1:0]   rq_op;
  logic [NREQ*DATA_W-1:0] rq_A;
  logic [NREQ*DATA_W-1:0] rq_B;
  logic [NREQ*TAG_W-1:0]  rq_tag;
  logic                   flush;
  logic                   dv_start;
  logic [OP_W-1:0]        dv_op;
  logic [DATA_W-1:0]      dv_A;
  logic [DATA_W-1:0]      dv_B;
  logic [DATA_W-1:0]      dv_res;
  logic [FLAG_W-1:0]      dv_flags;
  logic                   rt_valid;
  logic                   rt_stall;
  logic [1:0]             rt_req;
  logic [TAG_W-1:0]       rt_tag;
  logic [DATA_W-1:0]      rt_res;
  logic [FLAG_W-1:0]      rt_flags;
  logic                   busy;

  // Scheduler side.
  modport slave (
    input  rq_valid, rq_op, rq_A, rq_B, rq_tag, flush, dv_res, dv_flags, rt_stall,
    output rq_ready, dv_start, dv_op, dv_A, dv_B, rt_valid, rt_req, rt_tag, rt_res,
           rt_flags, busy
  );

  // Clusters, divider and writeback side.
  modport master (
    output rq_valid, rq_op, rq_A, rq_B, rq_tag, flush, dv_res, dv_flags, rt_stall,
    input  rq_ready, dv_start, dv_op, dv_A, dv_B, rt_valid, rt_req, rt_tag, rt_res,
           rt_flags, busy
  );

endinterface

// File: rtl/fpu_rr_pick.sv
// Rotating-priority picker: first set request at or above ptr, with wrap-around.
module fpu_rr_pick
  import fpu_div_pkg::*;
#(
  parameter int unsigned NREQ  = NREQ_DEF,
  parameter int unsigned IDX_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  localparam int unsigned PW = IDX_W + 1;

  logic [PW-1:0] pos;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    pos = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      pos = {1'b0, ptr} + PW'(k);
      if (pos >= PW'(NREQ)) pos = pos - PW'(NREQ);
      if (!any && req[pos]) begin
        gnt[pos] = 1'b1;
        idx      = IDX_W'(pos);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpu_div_sched.sv
// Shares one iterative divide/sqrt unit between the FPU clusters: round-robin
// grant, fixed-latency sequencing, and result hold until writeback accepts it.
module fpu_div_sched
  import fpu_div_pkg::*;
#(
  parameter int unsigned NREQ  = NREQ_DEF,
  parameter int unsigned LAT_S = LAT_S_DEF,
  parameter int unsigned LAT_D = LAT_D_DEF,
  parameter int unsigned TAG_W = TAG_W_DEF
) (
  input logic           clk,
  input logic           rst,
  fpu_div_sched_if.slave bus
);

  localparam int unsigned IDX_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned LAT_MAX = (LAT_D > LAT_S) ? LAT_D : LAT_S;
  localparam int unsigned CNT_W   = $clog2(LAT_MAX + 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dv_start_q, dv_start_d;
  div_cmd_t         cmd_q, cmd_d;
  div_rsp_t         rsp_q, rsp_d;
  logic [1:0]       rt_req_q, rt_req_d;
  logic [TAG_W-1:0] rt_tag_q, rt_tag_d;
  logic             rt_valid_q, rt_valid_d;
  logic             busy_q, busy_d;

  logic [NREQ-1:0]  pick_gnt;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic [NREQ-1:0]  rq_ready_c;

  fpu_rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req (bus.rq_valid),
    .ptr (rr_ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Next-state, counter and data capture; flush overrides everything at the end.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    cnt_d      = cnt_q;
    dv_start_d = 1'b0;
    cmd_d      = cmd_q;
    rsp_d      = rsp_q;
    rt_req_d   = rt_req_q;
    rt_tag_d   = rt_tag_q;
    rt_valid_d = rt_valid_q;
    rq_ready_c = '0;

    case (state_q)
      IDLE: begin
        if (!rst && !bus.flush && pick_any) begin
          rq_ready_c = pick_gnt;
          cmd_d.op   = bus.rq_op[pick_idx*OP_W +: OP_W];
          cmd_d.a    = bus.rq_A[pick_idx*DATA_W +: DATA_W];
          cmd_d.b    = bus.rq_B[pick_idx*DATA_W +: DATA_W];
          rt_tag_d   = bus.rq_tag[pick_idx*TAG_W +: TAG_W];
          rt_req_d   = 2'(pick_idx);
          rr_ptr_d   = (pick_idx == IDX_W'(NREQ - 1)) ? '0 : pick_idx + IDX_W'(1);
          dv_start_d = 1'b1;
          state_d    = START;
        end
      end
      START: begin
        cnt_d   = cmd_q.op[OP_DBL_BIT] ? CNT_W'(LAT_D) : CNT_W'(LAT_S);
        state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        // cnt reaches 1 exactly in cycle START+LAT, when the divider output is valid.
        if (cnt_q == CNT_W'(1)) begin
          rsp_d.res   = bus.dv_res;
          rsp_d.flags = bus.dv_flags;
          rt_valid_d  = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (!bus.rt_stall) begin
          rt_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.flush) begin
      state_d    = IDLE;
      cnt_d      = '0;
      rt_valid_d = 1'b0;
      dv_start_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      cnt_q      <= '0;
      dv_start_q <= 1'b0;
      cmd_q      <= '0;
      rsp_q      <= '0;
      rt_req_q   <= '0;
      rt_tag_q   <= '0;
      rt_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      cnt_q      <= cnt_d;
      dv_start_q <= dv_start_d;
      cmd_q      <= cmd_d;
      rsp_q      <= rsp_d;
      rt_req_q   <= rt_req_d;
      rt_tag_q   <= rt_tag_d;
      rt_valid_q <= rt_valid_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.rq_ready = rq_ready_c;
  assign bus.dv_start = dv_start_q;
  assign bus.dv_op    = cmd_q.op;
  assign bus.dv_A     = cmd_q.a;
  assign bus.dv_B     = cmd_q.b;
  assign bus.rt_valid = rt_valid_q;
  assign bus.rt_req   = rt_req_q;
  assign bus.rt_tag   = rt_tag_q;
  assign bus.rt_res   = rsp_q.res;
  assign bus.rt_flags = rsp_q.flags;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_fpu_div_sched.sv
// Directed bench for fpu_div_sched with a fixed-latency divider model.
module tb_fpu_div_sched;
  import fpu_div_pkg::*;

  localparam int unsigned NREQ  = 3;
  localparam int unsigned TAG_W = 9;
  localparam logic [DATA_W-1:0] JUNK = 68'hF_0BAD_0BAD_0BAD_0BAD;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fpu_div_sched_if #(.NREQ(NREQ), .TAG_W(TAG_W)) bus ();

  fpu_div_sched #(
    .NREQ  (NREQ),
    .LAT_S (10),
    .LAT_D (16),
    .TAG_W (TAG_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Divider model: output valid only in cycle START+LAT, junk otherwise.
  int                dcnt  = 0;
  logic              armed = 1'b0;
  logic [DATA_W-1:0] mres;
  logic [FLAG_W-1:0] mflg;
  always @(negedge clk) begin
    if (bus.dv_start) begin
      dcnt  = bus.dv_op[OP_DBL_BIT] ? 16 : 10;
      armed = 1'b1;
      mres  = bus.dv_A ^ bus.dv_B;
      mflg  = bus.dv_B[FLAG_W-1:0];
    end else if (dcnt > 0) begin
      dcnt--;
    end
    if (armed && dcnt == 0) begin
      bus.dv_res   = mres;
      bus.dv_flags = mflg;
      armed        = 1'b0;
    end else begin
      bus.dv_res   = JUNK;
      bus.dv_flags = '1;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [OP_W-1:0] op,
                         input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                         input logic [TAG_W-1:0] tag);
    bus.rq_valid[i]               = v;
    bus.rq_op[i*OP_W +: OP_W]     = op;
    bus.rq_A[i*DATA_W +: DATA_W]  = a;
    bus.rq_B[i*DATA_W +: DATA_W]  = b;
    bus.rq_tag[i*TAG_W +: TAG_W]  = tag;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++; if (bus.rq_ready !== 3'b000) begin errors++; $display("FAIL reset_ready: got %b expected 000", bus.rq_ready); end
    checks++; if (bus.dv_start !== 1'b0) begin errors++; $display("FAIL reset_dv_start: got %b expected 0", bus.dv_start); end
    checks++; if (bus.rt_valid !== 1'b0) begin errors++; $display("FAIL reset_rt_valid: got %b expected 0", bus.rt_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if ({bus.rt_req, bus.rt_tag, bus.rt_flags, bus.rt_res} !== '0) begin errors++; $display("FAIL reset_rt_data: got %h expected 0", {bus.rt_req, bus.rt_tag, bus.rt_flags, bus.rt_res}); end
    checks++; if ({bus.dv_op, bus.dv_A, bus.dv_B} !== '0) begin errors++; $display("FAIL reset_dv_data: got %h expected 0", {bus.dv_op, bus.dv_A, bus.dv_B}); end
    set_req(0, 1'b1, 13'h0001, 68'h1, 68'h2, 9'h001);
    #1;
    checks++; if (bus.rq_ready !== 3'b000) begin errors++; $display("FAIL reset_ready_req: got %b expected 000", bus.rq_ready); end
    set_req(0, 1'b0, '0, '0, '0, '0);
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    logic [DATA_W-1:0] a   = 68'h1_2345_6789_ABCD_EF01;
    logic [DATA_W-1:0] b   = 68'h0_FEDC_BA98_7654_3210;
    logic [DATA_W-1:0] exp = a ^ b;
    step();
    set_req(1, 1'b1, 13'h0005, a, b, 9'h0A5);
    #1;
    checks++; if (bus.rq_ready !== 3'b010) begin errors++; $display("FAIL single_grant: got %b expected 010", bus.rq_ready); end
    step();
    set_req(1, 1'b0, '0, '0, '0, '0);
    checks++; if (bus.dv_start !== 1'b1 || bus.busy !== 1'b1) begin errors++; $display("FAIL single_start: got start=%b busy=%b expected 1 1", bus.dv_start, bus.busy); end
    checks++; if (bus.dv_op !== 13'h0005 || bus.dv_A !== a || bus.dv_B !== b) begin errors++; $display("FAIL single_operands: got op=%h A=%h B=%h", bus.dv_op, bus.dv_A, bus.dv_B); end
    for (int k = 2; k <= 11; k++) begin
      step();
      checks++; if (bus.rt_valid !== 1'b0 || bus.dv_start !== 1'b0) begin errors++; $display("FAIL single_run_T%0d: got valid=%b start=%b expected 0 0", k, bus.rt_valid, bus.dv_start); end
    end
    step();
    checks++; if (bus.rt_valid !== 1'b1) begin errors++; $display("FAIL single_rt_valid: got %b expected 1", bus.rt_valid); end
    checks++; if (bus.rt_req !== 2'd1 || bus.rt_tag !== 9'h0A5) begin errors++; $display("FAIL single_owner: got req=%0d tag=%h expected 1 0a5", bus.rt_req, bus.rt_tag); end
    checks++; if (bus.rt_res !== exp || bus.rt_flags !== 11'h210) begin errors++; $display("FAIL single_result: got %h/%h expected %h/210", bus.rt_res, bus.rt_flags, exp); end
    step();
    checks++; if (bus.rt_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL single_retire: got valid=%b busy=%b expected 0 0", bus.rt_valid, bus.busy); end
  endtask

  task automatic test_double_stall();
    logic [DATA_W-1:0] a   = 68'hA_5555_0000_FFFF_1234;
    logic [DATA_W-1:0] b   = 68'h3_0F0F_1111_2222_0345;
    logic [DATA_W-1:0] exp = a ^ b;
    bus.rt_stall = 1'b1;
    step();
    set_req(0, 1'b1, 13'h0080, a, b, 9'h1C3);
    #1;
    checks++; if (bus.rq_ready !== 3'b001) begin errors++; $display("FAIL dbl_grant: got %b expected 001", bus.rq_ready); end
    step();
    set_req(0, 1'b0, '0, '0, '0, '0);
    checks++; if (bus.dv_start !== 1'b1 || bus.dv_op !== 13'h0080) begin errors++; $display("FAIL dbl_start: got start=%b op=%h expected 1 0080", bus.dv_start, bus.dv_op); end
    for (int k = 2; k <= 17; k++) begin
      step();
      checks++; if (bus.rt_valid !== 1'b0) begin errors++; $display("FAIL dbl_run_T%0d: got valid=%b expected 0", k, bus.rt_valid); end
    end
    step();
    checks++; if (bus.rt_valid !== 1'b1 || bus.rt_req !== 2'd0 || bus.rt_tag !== 9'h1C3) begin errors++; $display("FAIL dbl_rt_valid: got valid=%b req=%0d tag=%h expected 1 0 1c3", bus.rt_valid, bus.rt_req, bus.rt_tag); end
    checks++; if (bus.rt_res !== exp || bus.rt_flags !== 11'h345) begin errors++; $display("FAIL dbl_result: got %h/%h expected %h/345", bus.rt_res, bus.rt_flags, exp); end
    set_req(2, 1'b1, 13'h0001, 68'h7, 68'h9, 9'h0EE);
    #1;
    checks++; if (bus.rq_ready !== 3'b000) begin errors++; $display("FAIL dbl_hold_nogrant: got %b expected 000", bus.rq_ready); end
    for (int k = 19; k <= 21; k++) begin
      step();
      checks++; if (bus.rt_valid !== 1'b1 || bus.rt_res !== exp || bus.rt_tag !== 9'h1C3 || bus.rq_ready !== 3'b000) begin errors++; $display("FAIL dbl_hold_T%0d: got valid=%b res=%h tag=%h ready=%b", k, bus.rt_valid, bus.rt_res, bus.rt_tag, bus.rq_ready); end
      if (k == 21) bus.rt_stall = 1'b0;
    end
    step();
    checks++; if (bus.rt_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL dbl_idle: got valid=%b busy=%b expected 0 0", bus.rt_valid, bus.busy); end
    checks++; if (bus.rq_ready !== 3'b100) begin errors++; $display("FAIL dbl_next_grant: got %b expected 100", bus.rq_ready); end
    step();
    set_req(2, 1'b0, '0, '0, '0, '0);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
  endtask

  task automatic test_back_to_back();
    int exp_win[4] = '{0, 1, 2, 0};
    int g     = 0;
    int last  = 0;
    int owner = -1;
    do_reset();
    step();
    set_req(0, 1'b1, 13'h0001, 68'h11, 68'h22, 9'h010);
    set_req(1, 1'b1, 13'h0002, 68'h33, 68'h44, 9'h011);
    set_req(2, 1'b1, 13'h0004, 68'h55, 68'h66, 9'h012);
    #1;
    for (int c = 0; c < 80 && g < 4; c++) begin
      checks++; if ($countones(bus.rq_ready) > 1) begin errors++; $display("FAIL b2b_onehot: got %b at cycle %0d", bus.rq_ready, c); end
      if (bus.rt_valid === 1'b1) begin
        checks++; if (int'(bus.rt_req) != owner) begin errors++; $display("FAIL b2b_owner: got %0d expected %0d", bus.rt_req, owner); end
      end
      if (bus.rq_ready !== 3'b000) begin
        checks++; if (bus.rq_ready !== 3'(1 << exp_win[g])) begin errors++; $display("FAIL b2b_order%0d: got %b expected cluster %0d", g, bus.rq_ready, exp_win[g]); end
        if (g > 0) begin
          checks++; if (c - last != 13) begin errors++; $display("FAIL b2b_spacing%0d: got %0d expected 13", g, c - last); end
        end
        owner = exp_win[g];
        last  = c;
        g++;
      end
      step();
    end
    checks++; if (g != 4) begin errors++; $display("FAIL b2b_timeout: got %0d grants expected 4", g); end
    bus.rq_valid = '0;
    g = 0;
    while (bus.busy === 1'b1 && g < 30) begin
      step();
      g++;
    end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_drain: got busy=%b expected 0", bus.busy); end
  endtask

  task automatic test_flush_run();
    step();
    set_req(1, 1'b1, 13'h0003, 68'h0_1234, 68'h0_5678, 9'h033);
    #1;
    checks++; if (bus.rq_ready !== 3'b010) begin errors++; $display("FAIL flrun_grant: got %b expected 010", bus.rq_ready); end
    step();
    set_req(1, 1'b0, '0, '0, '0, '0);
    for (int k = 2; k <= 7; k++) step();
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL flrun_busy: got %b expected 1", bus.busy); end
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.rt_valid !== 1'b0) begin errors++; $display("FAIL flrun_idle: got busy=%b valid=%b expected 0 0", bus.busy, bus.rt_valid); end
    for (int k = 0; k < 14; k++) begin
      step();
      checks++; if (bus.rt_valid !== 1'b0) begin errors++; $display("FAIL flrun_no_result%0d: got %b expected 0", k, bus.rt_valid); end
    end
    set_req(0, 1'b1, 13'h0001, 68'h1, 68'h2, 9'h001);
    set_req(1, 1'b1, 13'h0001, 68'h3, 68'h4, 9'h002);
    set_req(2, 1'b1, 13'h0001, 68'h5, 68'h6, 9'h003);
    #1;
    checks++; if (bus.rq_ready !== 3'b100) begin errors++; $display("FAIL flrun_next_grant: got %b expected 100", bus.rq_ready); end
    step();
    bus.rq_valid = '0;
    bus.flush    = 1'b1;
    step();
    bus.flush = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL flrun_start_flush: got busy=%b expected 0", bus.busy); end
  endtask

  task automatic test_flush_idle();
    step();
    set_req(0, 1'b1, 13'h0000, 68'h8_0000_0000_0000_00F0, 68'h0_0000_0000_0000_0123, 9'h111);
    bus.flush = 1'b1;
    #1;
    checks++; if (bus.rq_ready !== 3'b000) begin errors++; $display("FAIL flidle_ready: got %b expected 000", bus.rq_ready); end
    step();
    checks++; if (bus.dv_start !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL flidle_nostart: got start=%b busy=%b expected 0 0", bus.dv_start, bus.busy); end
    bus.flush = 1'b0;
    #1;
    checks++; if (bus.rq_ready !== 3'b001) begin errors++; $display("FAIL flidle_regrant: got %b expected 001", bus.rq_ready); end
    step();
    set_req(0, 1'b0, '0, '0, '0, '0);
    checks++; if (bus.dv_start !== 1'b1) begin errors++; $display("FAIL flidle_start: got %b expected 1", bus.dv_start); end
  endtask

  task automatic test_rst_hold();
    logic [DATA_W-1:0] exp = 68'h8_0000_0000_0000_00F0 ^ 68'h0_0000_0000_0000_0123;
    int n = 0;
    bus.rt_stall = 1'b1;
    while (bus.rt_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    checks++; if (bus.rt_valid !== 1'b1 || bus.rt_res !== exp) begin errors++; $display("FAIL rsthold_result: got valid=%b res=%h expected 1 %h", bus.rt_valid, bus.rt_res, exp); end
    step();
    rst = 1'b1;
    step();
    checks++; if (bus.rt_valid !== 1'b0 || bus.busy !== 1'b0 || bus.dv_start !== 1'b0) begin errors++; $display("FAIL rsthold_ctrl: got valid=%b busy=%b start=%b expected 0 0 0", bus.rt_valid, bus.busy, bus.dv_start); end
    checks++; if ({bus.rt_req, bus.rt_tag, bus.rt_res, bus.rt_flags, bus.dv_op, bus.dv_A, bus.dv_B} !== '0) begin errors++; $display("FAIL rsthold_data: got nonzero rt_res=%h dv_A=%h", bus.rt_res, bus.dv_A); end
    rst          = 1'b0;
    bus.rt_stall = 1'b0;
    set_req(0, 1'b1, 13'h0001, 68'h1, 68'h2, 9'h001);
    set_req(1, 1'b1, 13'h0001, 68'h3, 68'h4, 9'h002);
    set_req(2, 1'b1, 13'h0001, 68'h5, 68'h6, 9'h003);
    #1;
    checks++; if (bus.rq_ready !== 3'b001) begin errors++; $display("FAIL rsthold_ptr: got %b expected 001", bus.rq_ready); end
    step();
    bus.rq_valid = '0;
    bus.flush    = 1'b1;
    step();
    bus.flush = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    bus.rq_valid = '0;
    bus.rq_op    = '0;
    bus.rq_A     = '0;
    bus.rq_B     = '0;
    bus.rq_tag   = '0;
    bus.flush    = 1'b0;
    bus.rt_stall = 1'b0;
    test_reset();
    test_single();
    test_double_stall();
    test_back_to_back();
    test_flush_run();
    test_flush_idle();
    test_rst_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
